// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// master drives the operands and start; slave returns status and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, S, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, S, Cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder evaluation per clock, LSB first,
// carry held in a flop, sum assembled in a shift register and published on completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] a_sh_next;
  logic [WIDTH-1:0] b_sh_next;
  logic [WIDTH-1:0] sum_sh_next;
  logic             accept;

  // The single full-adder cell this wrapper serialises.
  assign sum_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign carry_next = (a_sh_reg[0] & b_sh_reg[0])
                    | (a_sh_reg[0] & carry_reg)
                    | (b_sh_reg[0] & carry_reg);

  // Operands drain LSB-first with zeros filling from the top; the sum fills from the top.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_sh_next[gi]   = a_sh_reg[gi + 1];
      assign b_sh_next[gi]   = b_sh_reg[gi + 1];
      assign sum_sh_next[gi] = sum_sh_reg[gi + 1];
    end
  endgenerate

  assign a_sh_next[WIDTH-1]   = 1'b0;
  assign b_sh_next[WIDTH-1]   = 1'b0;
  assign sum_sh_next[WIDTH-1] = sum_bit;

  // A new request is taken whenever no addition is in flight, including the DONE cycle.
  assign accept = bus.start && (state_reg != SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      s_reg      <= '0;
      cout_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            a_sh_reg   <= bus.A;
            b_sh_reg   <= bus.B;
            carry_reg  <= bus.Cin;
            sum_sh_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= SHIFT;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end

        SHIFT: begin
          a_sh_reg   <= a_sh_next;
          b_sh_reg   <= b_sh_next;
          sum_sh_reg <= sum_sh_next;
          carry_reg  <= carry_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            // sum_sh_next already holds the final bit at the MSB.
            s_reg     <= sum_sh_next;
            cout_reg  <= carry_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.S    = s_reg;
  assign bus.Cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected {Cout,S},
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc;
  int busy_cnt;

  logic [W:0] exp_q[$];
  logic [W:0] mon_exp;
  logic       prev_done = 1'b0;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done got=%0h required=no pulse", {bus.Cout, bus.S});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.Cout, bus.S} !== mon_exp) begin
          fails++;
          $display("FAIL result got=%0h required=%0h", {bus.Cout, bus.S}, mon_exp);
        end else begin
          $display("[TB] done: {Cout,S}=%0h", {bus.Cout, bus.S});
        end
      end
      if (prev_done) begin
        tests++;
        fails++;
        $display("FAIL done_width got=2+ cycles required=1 cycle");
      end
    end
    prev_done <= bus.done;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input bit push);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = c;
    bus.start = 1'b1;
    if (push) exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    $display("[TB] issue A=%0h B=%0h Cin=%0b", a, b, c);
    @(negedge clk);
    bus.start = 1'b0;
    cyc       = 0;
    busy_cnt  = bus.busy ? 1 : 0;
    check("accept_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.busy) busy_cnt++;
  endtask

  task automatic wait_done();
    while (!bus.done && cyc < 40) step();
    check("latency", 32'(cyc), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
  endtask

  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    issue(a, b, c, 1'b1);
    wait_done();
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_S",    32'(bus.S),    32'd0);
    check("reset_Cout", 32'(bus.Cout), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_add(8'h00, 8'h00, 1'b0);
    run_add(8'h3C, 8'h42, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0);
    run_add(8'hA5, 8'h5A, 1'b1);

    // start pulsed mid-SHIFT must be ignored; then back-to-back from DONE.
    @(negedge clk);
    issue(8'h12, 8'h34, 1'b0, 1'b1);
    step();
    step();
    bus.A     = 8'h01;
    bus.B     = 8'h01;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done();
    issue(8'h77, 8'h11, 1'b1, 1'b1);
    wait_done();

    // Reset during the fourth SHIFT cycle discards the operation.
    @(negedge clk);
    issue(8'hF0, 8'h0F, 1'b1, 1'b0);
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("midrst_S",    32'(bus.S),    32'd0);
    check("midrst_Cout", 32'(bus.Cout), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    run_add(8'h10, 8'h20, 1'b1);

    // Full-adder truth table on bit 0.
    for (int i = 0; i < 8; i++) begin
      run_add({7'b0, i[2]}, {7'b0, i[1]}, i[0]);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
